// File: rtl/psw_unit.sv
// XM23 program-status-word unit: computes ALU flags, holds the architectural PSW
// and keeps a LIFO save stack of PSW values for exception entry and RETI.
module psw_unit #(
    parameter int          DATA_W      = 16,
    parameter int          STACK_DEPTH = 4,
    parameter logic [15:0] RESET_PSW   = 16'h00E0,
    localparam int         CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] result,
    input  logic              flag_en,
    input  logic              flag_mode,
    input  logic [4:0]        setcc,
    input  logic [4:0]        clrcc,
    input  logic              wr_en,
    input  logic [15:0]       wr_data,
    input  logic              push,
    input  logic [15:0]       push_psw,
    input  logic              pop,
    output logic [15:0]       psw_q,
    output logic [15:0]       psw_next,
    output logic [CNT_W-1:0]  stack_cnt,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    localparam int               IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    localparam int BIT_C = 0;
    localparam int BIT_Z = 1;
    localparam int BIT_N = 2;
    localparam int BIT_V = 4;

    logic [15:0]      stack_mem [STACK_DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic             err_q;
    logic             err_next;
    logic             stack_we;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;

    logic bm;
    logic am;
    logic rm;
    logic flag_c;
    logic flag_v;
    logic flag_z;
    logic flag_n;

    logic [4:0] cc_base;
    logic [4:0] cc_upd;

    // Only the operand sign bits feed the flag equations.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a[DATA_W-2:0], b[DATA_W-2:0]};

    assign bm = b[DATA_W-1];
    assign am = a[DATA_W-1];
    assign rm = result[DATA_W-1];

    // b arrives pre-complemented for subtract, so one carry/overflow table serves both.
    assign flag_c = (~bm & am & ~rm) | (bm & ~am & ~rm) | (bm & am);
    assign flag_v = (~bm & ~am & rm) | (bm & am & ~rm);
    assign flag_z = (result == '0);
    assign flag_n = rm;

    assign stack_full  = (cnt_q == DEPTH_C);
    assign stack_empty = (cnt_q == '0);
    assign stack_cnt   = cnt_q;
    assign stack_err   = err_q;

    assign push_idx = IDX_W'(cnt_q);
    assign top_idx  = IDX_W'(cnt_q - ONE_C);

    always_comb begin
        cc_base = psw_q[4:0];
        if (flag_en) begin
            cc_base[BIT_Z] = flag_z;
            cc_base[BIT_N] = flag_n;
            if (!flag_mode) begin
                cc_base[BIT_C] = flag_c;
                cc_base[BIT_V] = flag_v;
            end
        end
        cc_upd = (cc_base | setcc) & ~clrcc;
    end

    // Single prioritised next-state decode; psw_next doubles as the forwarding path.
    always_comb begin
        psw_next = psw_q;
        cnt_next = cnt_q;
        err_next = err_q;
        stack_we = 1'b0;
        if (rst) begin
            psw_next = RESET_PSW;
            cnt_next = '0;
            err_next = 1'b0;
        end else if (pop) begin
            if (stack_empty) begin
                err_next = 1'b1;
            end else begin
                psw_next = stack_mem[top_idx];
                cnt_next = cnt_q - ONE_C;
            end
        end else if (push) begin
            if (stack_full) begin
                err_next = 1'b1;
            end else begin
                stack_we = 1'b1;
                psw_next = push_psw;
                cnt_next = cnt_q + ONE_C;
            end
        end else if (wr_en) begin
            psw_next = wr_data;
        end else begin
            psw_next = {psw_q[15:5], cc_upd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psw_q <= RESET_PSW;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            psw_q <= psw_next;
            cnt_q <= cnt_next;
            err_q <= err_next;
        end
    end

    // Stack contents need no reset; only the count defines which entries are live.
    always_ff @(posedge clk) begin
        if (stack_we) begin
            stack_mem[push_idx] <= psw_q;
        end
    end

endmodule

// File: doc/psw_unit.md
Name: psw_unit

Overview:
Registered, parametrised program-status-word unit for the XM23 pipeline, the successor of the combinational flag generator.
- Computes C/Z/N/V from an ALU result of configurable width, in arithmetic or logic mode.
- Holds the architectural PSW and applies masked flag updates, direct writes and SETCC/CLRCC.
- Provides a PSW save/restore stack of configurable depth for exception entry and RETI.
- Sits after the execute stage; its combinational next-PSW output is forwarded to the branch-condition logic.

Parameters:
DATA_W, 16, width of a, b and result operands (at least 2)
STACK_DEPTH, 4, number of PSW entries in the save stack (at least 1)
RESET_PSW, 16'h00E0, PSW value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
a  in  DATA_W  ALU source operand
b  in  DATA_W  ALU destination operand, already complemented by the ALU for subtract
result  in  DATA_W  ALU result
flag_en  in  1  apply computed flags this cycle
flag_mode  in  1  0 = arithmetic (C,Z,N,V); 1 = logic (Z,N only; C,V held)
setcc  in  5  bits to set among {V,SLP,N,Z,C} = PSW[4:0]
clrcc  in  5  bits to clear in PSW[4:0]
wr_en  in  1  direct full-PSW write
wr_data  in  16  direct write value
push  in  1  exception entry: save PSW, load push_psw
push_psw  in  16  PSW loaded on exception entry
pop  in  1  RETI: restore PSW from stack
psw_q  out  16  registered architectural PSW
psw_next  out  16  combinational value psw_q takes at the next edge
stack_cnt  out  $clog2(STACK_DEPTH+1)  occupied stack entries
stack_full  out  1  stack_cnt == STACK_DEPTH
stack_empty  out  1  stack_cnt == 0
stack_err  out  1  sticky flag: push when full or pop when empty

Behaviour:
PSW bit layout:
- C = bit 0, Z = bit 1, N = bit 2, SLP = bit 3, V = bit 4.
- Bits 15:5 change only via rst, wr_en, push or pop.

Flag computation, with MSBs bm = b[DATA_W-1], am = a[DATA_W-1], rm = result[DATA_W-1]:
- C = 1 for (bm,am,rm) in {010, 100, 110, 111}; otherwise 0.
- V = 1 for (bm,am,rm) in {001, 110}; otherwise 0.
- Z = (result == 0).
- N = rm.

Reset (rst high at a clock edge):
- psw_q = RESET_PSW, stack_cnt = 0, stack_err = 0.
- Stack contents become don't-care.
- Reset overrides every other input in that cycle, including a push or pop in progress.

Next-state priority, highest first (exactly one action per cycle):
1. pop. If the stack is not empty: psw_q <= top entry, stack_cnt decrements. If empty: psw_q unchanged, stack_err <= 1.
2. push. If the stack is not full: top <= psw_q (the pre-edge value), psw_q <= push_psw, stack_cnt increments. If full: psw_q and stack unchanged, stack_err <= 1.
3. wr_en. psw_q <= wr_data.
4. Flag/CC update. Starting from psw_q:
   - If flag_en: replace C,Z,N,V (flag_mode 0), or Z,N only (flag_mode 1).
   - Then OR in setcc.
   - Then clear clrcc. clrcc wins when a bit is in both.
5. Otherwise psw_q holds.

Same-cycle combinations:
- push and pop together: pop wins. push is ignored without error.
- Lower-priority requests in a push, pop or wr_en cycle are dropped silently.

Stack timing and status:
- The stack is LIFO, depth STACK_DEPTH.
- stack_full, stack_empty and stack_cnt reflect the registered count.
- A push in cycle n followed by a pop in cycle n+1 returns the PSW value saved in cycle n.

Latency and forwarding:
- psw_next is purely combinational from the current inputs and state.
- psw_q equals the previous cycle's psw_next.
- Updates have one-cycle latency; no stall or handshake.

Arithmetic:
- All flag logic is width-generic; no truncation inside the block.
- stack_err is sticky and cleared only by rst.

Test Plan:
1. DATA_W=16, flag_en=1, mode 0, a=16'h7FFF, b=16'h0001, result=16'h8000 -> psw_next[4:0]=5'b10100 (V,N); psw_q matches after the edge.
2. a=16'hFFFF, b=16'h0001, result=16'h0000, mode 0 -> C=1, Z=1, N=0, V=0. Then mode 1 with result=16'h8000 -> Z=0, N=1, while C=1 and V=0 are held.
3. psw_q=16'h0000; setcc=5'b00101, clrcc=5'b00100, flag_en=0 -> psw_q[4:0]=5'b00001.
4. STACK_DEPTH=4, psw_q=16'h1234; push five times with push_psw=16'h0A00..16'h0A04:
   - After the 4th push: stack_full=1.
   - The 5th push is ignored, stack_err=1, psw_q=16'h0A03.
   - Four pops restore 16'h0A02, 16'h0A01, 16'h0A00, 16'h1234 in that order, then stack_empty=1.
5. Same cycle: push=1, pop=1, wr_en=1 with 1 entry stacked (16'h00E5) -> psw_q=16'h00E5, stack_cnt=0, stack_err stays 0.
6. Assert rst in the same cycle as a push, with stack_cnt=2 and stack_err=1 -> psw_q=RESET_PSW (16'h00E0), stack_cnt=0, stack_err=0, stack_empty=1.
